// File: rtl/masked_sbox_pkg.sv
// Shared types and defaults for the masked S-box sequencer.
package masked_sbox_pkg;

  localparam int NBYTES_DEF   = 16;
  localparam int SBOX_LAT_DEF = 2;
  localparam int RAND_W_DEF   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  // One extra bit so a counter can hold NBYTES itself without wrapping.
  function automatic int idx_w(input int nbytes);
    return $clog2(nbytes) + 1;
  endfunction

endpackage

// File: rtl/masked_sbox_valid_pipe.sv
// Shift register carrying issue-valid tags alongside the S-box pipeline.
// Synchronous active-low clear drops any tags still in flight.
module masked_sbox_valid_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic clr_n,
  input  logic din,
  output logic tail
);

  logic [DEPTH-1:0] pipe_q;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (!clr_n) pipe_q <= '0;
        else        pipe_q <= din;
      end
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (!clr_n) pipe_q <= '0;
        else        pipe_q <= {pipe_q[DEPTH-2:0], din};
      end
    end
  endgenerate

  assign tail = pipe_q[DEPTH-1];

endmodule

// File: rtl/masked_sbox_seq.sv
// Streams a two-share state one byte per cycle through the masked S-box
// pipeline and collects the shared results. Define MASKED_SBOX_SEQ_ZEROIZE_EN
// to wipe buffer bytes once they are no longer needed.
//
// state | meaning
// IDLE  | waiting for start, buffers hold last contents
// ISSUE | one byte per cycle when a fresh random word is offered
// DRAIN | all bytes issued, waiting for the pipeline to empty
// DONE  | result valid, waiting for consumer handshake
module masked_sbox_seq
  import masked_sbox_pkg::*;
#(
  parameter int NBYTES   = NBYTES_DEF,
  parameter int SBOX_LAT = SBOX_LAT_DEF,
  parameter int RAND_W   = RAND_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   state_in_sh0,
  input  logic [8*NBYTES-1:0]   state_in_sh1,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   state_out_sh0,
  output logic [8*NBYTES-1:0]   state_out_sh1,
  input  logic [RAND_W-1:0]     rnd_data,
  input  logic                  rnd_valid,
  output logic                  rnd_ready,
  output logic [7:0]            sbox_in_sh0,
  output logic [7:0]            sbox_in_sh1,
  output logic [RAND_W-1:0]     sbox_rnd,
  input  logic [7:0]            sbox_out_sh0,
  input  logic [7:0]            sbox_out_sh1
);

  localparam int IW = idx_w(NBYTES);
  localparam int AW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  seq_state_e state_q, state_d;
  logic [IW-1:0] issue_idx_q, collect_idx_q;
  logic [7:0] in_sh0_q  [NBYTES];
  logic [7:0] in_sh1_q  [NBYTES];
  logic [7:0] out_sh0_q [NBYTES];
  logic [7:0] out_sh1_q [NBYTES];

  logic issue_fire, vp_tail, start_fire, handshake;

  assign issue_fire = (state_q == ISSUE) && rnd_valid;
  assign start_fire = (state_q == IDLE) && start;
  assign handshake  = (state_q == DONE) && out_ready;
  assign busy       = (state_q != IDLE);
  assign out_valid  = (state_q == DONE);

  masked_sbox_valid_pipe #(.DEPTH(SBOX_LAT)) u_valid_pipe (
    .clk   (clk),
    .clr_n (rst_n),
    .din   (issue_fire),
    .tail  (vp_tail)
  );

  // Shares are muxed independently; nothing here ever combines them.
  always_comb begin
    sbox_in_sh0 = '0;
    sbox_in_sh1 = '0;
    sbox_rnd    = '0;
    rnd_ready   = 1'b0;
    if (issue_fire) begin
      sbox_in_sh0 = in_sh0_q[issue_idx_q[AW-1:0]];
      sbox_in_sh1 = in_sh1_q[issue_idx_q[AW-1:0]];
      sbox_rnd    = rnd_data;
      rnd_ready   = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ISSUE;
      ISSUE:   if (issue_fire && (issue_idx_q == IW'(NBYTES - 1))) state_d = DRAIN;
      DRAIN:   if (collect_idx_q == IW'(NBYTES)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      issue_idx_q   <= '0;
      collect_idx_q <= '0;
      for (int i = 0; i < NBYTES; i++) begin
        in_sh0_q[i]  <= '0;
        in_sh1_q[i]  <= '0;
        out_sh0_q[i] <= '0;
        out_sh1_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;

      if (start_fire) begin
        issue_idx_q   <= '0;
        collect_idx_q <= '0;
        for (int i = 0; i < NBYTES; i++) begin
          in_sh0_q[i] <= state_in_sh0[8*i +: 8];
          in_sh1_q[i] <= state_in_sh1[8*i +: 8];
        end
      end

      if (issue_fire) begin
        issue_idx_q <= issue_idx_q + 1'b1;
`ifdef MASKED_SBOX_SEQ_ZEROIZE_EN
        in_sh0_q[issue_idx_q[AW-1:0]] <= '0;
        in_sh1_q[issue_idx_q[AW-1:0]] <= '0;
`endif
      end

      if (vp_tail) begin
        out_sh0_q[collect_idx_q[AW-1:0]] <= sbox_out_sh0;
        out_sh1_q[collect_idx_q[AW-1:0]] <= sbox_out_sh1;
        collect_idx_q <= collect_idx_q + 1'b1;
      end

`ifdef MASKED_SBOX_SEQ_ZEROIZE_EN
      if (handshake) begin
        for (int i = 0; i < NBYTES; i++) begin
          out_sh0_q[i] <= '0;
          out_sh1_q[i] <= '0;
        end
      end
`endif
    end
  end

  generate
    for (genvar g = 0; g < NBYTES; g++) begin : g_out
      assign state_out_sh0[8*g +: 8] = out_sh0_q[g];
      assign state_out_sh1[8*g +: 8] = out_sh1_q[g];
    end
  endgenerate

endmodule

// File: tb/tb_masked_sbox_seq.sv
// Directed bench for masked_sbox_seq with a behavioural two-stage masked S-box.
module tb_masked_sbox_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] state_in_sh0, state_in_sh1;
  logic         busy, out_valid, out_ready;
  logic [127:0] state_out_sh0, state_out_sh1;
  logic [7:0]   rnd_data;
  logic         rnd_valid, rnd_ready;
  logic [7:0]   sbox_in_sh0, sbox_in_sh1, sbox_rnd;
  logic [7:0]   sbox_out_sh0 = '0, sbox_out_sh1 = '0;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0]   exp_q[$];
  logic [127:0] exp_packed;

  masked_sbox_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .state_in_sh0(state_in_sh0), .state_in_sh1(state_in_sh1),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .state_out_sh0(state_out_sh0), .state_out_sh1(state_out_sh1),
    .rnd_data(rnd_data), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .sbox_in_sh0(sbox_in_sh0), .sbox_in_sh1(sbox_in_sh1), .sbox_rnd(sbox_rnd),
    .sbox_out_sh0(sbox_out_sh0), .sbox_out_sh1(sbox_out_sh1)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = '0; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] aes_sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = '0;
    for (int y = 1; y < 256; y++)
      if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Two-cycle masked S-box model: output share 0 is the fresh mask.
  logic [7:0] m_sh0 = '0, m_sh1 = '0, m_rnd = '0;
  always @(posedge clk) begin
    m_sh0 <= sbox_in_sh0;
    m_sh1 <= sbox_in_sh1;
    m_rnd <= sbox_rnd;
    sbox_out_sh0 <= m_rnd;
    sbox_out_sh1 <= aes_sbox(m_sh0 ^ m_sh1) ^ m_rnd;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [127:0] s0, input logic [127:0] s1,
                        input bit alt, input int exp_lat, input string tag);
    int lat, pulses;
    state_in_sh0 = s0;
    state_in_sh1 = s1;
    start = 1'b1;
    for (int i = 0; i < 16; i++) exp_q.push_back(aes_sbox(s0[8*i +: 8] ^ s1[8*i +: 8]));
    tick();
    start = 1'b0;
    check({tag, "_busy"}, 128'(busy), 128'(1));
    lat = 0;
    pulses = 0;
    for (int k = 0; k < 200 && !out_valid; k++) begin
      rnd_valid = alt ? ((k % 2) == 0) : 1'b1;
      rnd_data  = 8'($urandom);
      #1;
      if (!rnd_valid) begin
        check({tag, "_bubble"}, {rnd_ready, sbox_rnd, sbox_in_sh0, sbox_in_sh1}, '0);
      end else if (pulses < 16) begin
        check({tag, "_issue"}, {rnd_ready, sbox_rnd, sbox_in_sh0, sbox_in_sh1},
              {1'b1, rnd_data, s0[8*pulses +: 8], s1[8*pulses +: 8]});
      end else begin
        check({tag, "_drain_ready"}, 128'(rnd_ready), '0);
      end
      if (rnd_ready) pulses++;
      @(posedge clk);
      #1;
      lat++;
    end
    rnd_valid = 1'b0;
    check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    check({tag, "_pulses"}, 128'(pulses), 128'(16));
    for (int i = 0; i < 16; i++) begin
      if (exp_q.size() == 0) begin
        check({tag, "_sb_empty"}, 128'(0), 128'(1));
      end else begin
        exp_packed[8*i +: 8] = exp_q.pop_front();
        check({tag, "_byte"}, {120'(i), state_out_sh0[8*i +: 8] ^ state_out_sh1[8*i +: 8]},
              {120'(i), exp_packed[8*i +: 8]});
      end
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_hs"}, {busy, out_valid}, '0);
  endtask

  initial begin
    logic [127:0] r0, r1;
    int pulses;
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
    rnd_valid = 1'b0; rnd_data = '0;
    state_in_sh0 = '0; state_in_sh1 = '0;
    tick(); tick();
    rst_n = 1'b1;
    check("reset_ctl", {busy, out_valid, rnd_ready}, '0);
    check("reset_sbox", {sbox_in_sh0, sbox_in_sh1, sbox_rnd}, '0);
    check("reset_out", state_out_sh0 | state_out_sh1, '0);

    run_op('0, '0, 1'b0, 19, "zero");
    handshake("zero");

    r0 = '0; r1 = '0;
    r0[7:0] = 8'h53; r0[15:8] = 8'hA5; r1[15:8] = 8'hF6;
    run_op(r0, r1, 1'b0, 19, "masked");
    check("masked_b0", 128'(exp_packed[7:0]), 128'(8'hED));
    check("masked_b1", 128'(exp_packed[15:8]), 128'(8'hED));
    handshake("masked");

    run_op('0, '0, 1'b1, 34, "starve");
    handshake("starve");

    r0 = {$urandom, $urandom, $urandom, $urandom};
    r1 = {$urandom, $urandom, $urandom, $urandom};
    run_op(r0, r1, 1'b0, 19, "bp");
    for (int k = 0; k < 10; k++) begin
      start = (k == 4);
      tick();
      check("bp_ctl", {busy, out_valid}, 128'(2'b11));
      check("bp_data", state_out_sh0 ^ state_out_sh1, exp_packed);
    end
    start = 1'b0;
    handshake("bp");
    tick();
    check("bp_idle", 128'(busy), '0);
`ifdef MASKED_SBOX_SEQ_ZEROIZE_EN
    check("post_hs_sh0", state_out_sh0, '0);
    check("post_hs_sh1", state_out_sh1, '0);
`else
    check("post_hs_keep", state_out_sh0 ^ state_out_sh1, exp_packed);
`endif

    r0 = {$urandom, $urandom, $urandom, $urandom};
    r1 = {$urandom, $urandom, $urandom, $urandom};
    state_in_sh0 = r0; state_in_sh1 = r1;
    start = 1'b1;
    tick();
    start = 1'b0;
    rnd_valid = 1'b1;
    pulses = 0;
    for (int k = 0; k < 40 && pulses < 7; k++) begin
      rnd_data = 8'($urandom);
      #1;
      if (rnd_ready) pulses++;
      tick();
    end
    check("rst_mid_pulses", 128'(pulses), 128'(7));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    rnd_valid = 1'b1;
    #1;
    check("rst_mid_ctl", {busy, out_valid, rnd_ready}, '0);
    check("rst_mid_sbox", {sbox_in_sh0, sbox_in_sh1, sbox_rnd}, '0);
    check("rst_mid_out", state_out_sh0 | state_out_sh1, '0);
    rnd_valid = 1'b0;
    exp_q.delete();

    r0 = {$urandom, $urandom, $urandom, $urandom};
    r1 = {$urandom, $urandom, $urandom, $urandom};
    run_op(r0, r1, 1'b0, 19, "after_rst");
    handshake("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
